ibex_instr_realign_fifo: RTL



---
 rtl/ibex_instr_realign_fifo_pkg.sv | 21 ++
 rtl/ibex_instr_realign_fifo_if.sv | 37 +++
 rtl/ibex_instr_realign_fifo.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ibex_instr_realign_fifo_pkg.sv
// Shared fetch-side types and helpers for the instruction realign FIFO.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   fifo_entry_t  - one stored fetch word plus its bus error flag
//   is_compressed - true when a halfword starts a 16-bit instruction
package ibex_instr_realign_fifo_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fifo_entry_t;

  // RVC: a halfword begins a compressed instruction unless its two low
  // bits are both set.
  function automatic logic is_compressed(input logic [15:0] halfword);
    return (halfword & 16'h0003) != 16'h0003;
  endfunction

endpackage

// File: rtl/ibex_instr_realign_fifo_if.sv
// Handshake bundle between the fetch side, the realign FIFO and the decoder.
// Latency: n/a (wiring only).
// Backpressure: out_ready_i stalls the consumer side; busy_o throttles requests.
//
// Ports:
//   clear_i/in_addr_i            - flush and restart at a new PC
//   in_valid_i/in_rdata_i/in_err_i - fetched word from memory
//   busy_o                       - FIFO nearly full, stop issuing requests
//   out_*                        - realigned instruction towards the decoder
// modport slave is the FIFO's view; modport master is the environment's view.
interface ibex_instr_realign_fifo_if;
  import ibex_instr_realign_fifo_pkg::*;

  logic        clear_i;
  logic [31:0] in_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        busy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  modport master (
    output clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    input  busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
  );

  modport slave (
    input  clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    output busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
  );

endinterface

// File: rtl/ibex_instr_realign_fifo.sv
// Shift FIFO of fetched words that realigns mixed 16/32-bit instructions.
// Latency: 1 cycle from in_valid_i to out_valid_o (no bypass).
// Backpressure: holds outputs while out_ready_i=0; busy_o high at occupancy >= DEPTH-1.
//
// Ports:
//   clk_i, rst_i - clock and asynchronous active-high reset
//   bus          - ibex_instr_realign_fifo_if.slave (fetch input, decoder output)
module ibex_instr_realign_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input logic                      clk_i,
  input logic                      rst_i,
  ibex_instr_realign_fifo_if.slave bus
);
  import ibex_instr_realign_fifo_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fifo_entry_t   entries_q [DEPTH];
  fifo_entry_t   entries_d [DEPTH];
  logic [CW-1:0] occ_q, occ_d, occ_pop;
  logic [31:0]   pc_q, pc_d;

  logic          v0, v1, lo_c, hi_c;
  logic          out_valid;
  logic [31:0]   out_rdata;
  logic          out_err, out_err_plus2;
  logic          pop_sel, pop, push, handshake;
  logic [31:0]   pc_inc;

  // Instruction selection. pc_q[1] says whether the next instruction starts
  // in the low or the high halfword of entry 0.
  always_comb begin
    v0            = occ_q != '0;
    v1            = occ_q >= CW'(2);
    lo_c          = is_compressed(entries_q[0].rdata[15:0]);
    hi_c          = is_compressed(entries_q[0].rdata[31:16]);
    out_valid     = 1'b0;
    out_rdata     = '0;
    out_err       = 1'b0;
    out_err_plus2 = 1'b0;
    pop_sel       = 1'b0;
    pc_inc        = 32'd0;
    if (!pc_q[1]) begin
      out_valid = v0;
      out_err   = entries_q[0].err;
      if (lo_c) begin
        // Upper half still holds the next instruction: keep the word.
        out_rdata = {16'h0, entries_q[0].rdata[15:0]};
        pc_inc    = 32'd2;
      end else begin
        out_rdata = entries_q[0].rdata;
        pop_sel   = 1'b1;
        pc_inc    = 32'd4;
      end
    end else if (hi_c) begin
      out_valid = v0;
      out_rdata = {16'h0, entries_q[0].rdata[31:16]};
      out_err   = entries_q[0].err;
      pop_sel   = 1'b1;
      pc_inc    = 32'd2;
    end else begin
      // A 32-bit instruction straddles entries 0 and 1. A faulted first
      // half is reported at once rather than waiting for a word that may
      // never arrive.
      out_valid     = v1 | (v0 & entries_q[0].err);
      out_rdata     = {entries_q[1].rdata[15:0], entries_q[0].rdata[31:16]};
      out_err       = entries_q[0].err | entries_q[1].err;
      out_err_plus2 = entries_q[1].err & ~entries_q[0].err;
      pop_sel       = 1'b1;
      pc_inc        = 32'd4;
    end
  end

  assign handshake = out_valid & bus.out_ready_i;
  assign pop       = handshake & pop_sel;
  assign occ_pop   = occ_q - CW'(pop);
  assign push      = bus.in_valid_i & (occ_pop != CW'(DEPTH));
  assign occ_d     = occ_pop + CW'(push);
  assign pc_d      = handshake ? pc_q + pc_inc : pc_q;

  // Shift on pop, then write the new word right behind the survivors.
  always_comb begin
    entries_d = entries_q;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        entries_d[i] = entries_q[i+1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && occ_pop == CW'(i)) begin
        entries_d[i] = '{rdata: bus.in_rdata_i, err: bus.in_err_i};
      end
    end
  end

  // clear_i wins over everything: same-cycle pop and push belong to the
  // old stream and are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      occ_q <= '0;
      pc_q  <= '0;
    end else if (bus.clear_i) begin
      occ_q <= '0;
      pc_q  <= bus.in_addr_i;
    end else begin
      entries_q <= entries_d;
      occ_q     <= occ_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.busy_o          = occ_q >= CW'(DEPTH - 1);
  assign bus.out_valid_o     = out_valid;
  assign bus.out_rdata_o     = out_rdata;
  assign bus.out_addr_o      = pc_q;
  assign bus.out_err_o       = out_err;
  assign bus.out_err_plus2_o = out_err_plus2;

  // Upstream must honour busy_o; a push into a full FIFO without a pop is lost.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.in_valid_i && !bus.clear_i && !pop && occ_q == CW'(DEPTH)));

endmodule
